// File: rtl/call_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : call_button_conditioner
// Purpose  : Synchronises and debounces eight elevator call buttons, emits
//            one-cycle request pulses, owns the call lamps and flags stuck
//            buttons. Optional macro LAMP_BLINK_EN blinks faulted lamps.
// Revision : 1.0 - initial release
// ============================================================================
module call_button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int STUCK_CYCLES      = 2000,
    parameter int BLINK_HALF_PERIOD = 25
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [7:0] btn_raw_i,
    input  logic [2:0] current_floor_i,
    input  logic       door_open_i,
    input  logic       fault_clr_i,
    output logic [7:0] req_o,
    output logic [7:0] lamp_o,
    output logic [7:0] fault_o,
    output logic       any_fault_o
);
    localparam int c_DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_HOLD_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_ONE   = c_DEB_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(STUCK_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

    typedef enum logic [2:0] {
        S_REL = 3'd0,
        S_DBP = 3'd1,
        S_PRS = 3'd2,
        S_DBR = 3'd3,
        S_STK = 3'd4
    } state_e;

    logic [7:0] sync1_q, sync_q;
    logic [7:0] w_serve, w_accept, w_stk_set;
    logic [7:0] req_q, req_d, lamp_q, lamp_d, fault_q, fault_d;
    logic       any_fault_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync_q  <= sync1_q;
        end
    end

    always_comb begin
        w_serve                  = '0;
        w_serve[current_floor_i] = door_open_i;
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_floor
        state_e              state_q, state_d;
        logic [c_DEB_W-1:0]  deb_q, deb_d;
        logic [c_HOLD_W-1:0] hold_q, hold_d;
        logic                accept, stk_set;

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                state_q <= S_REL;
                deb_q   <= '0;
                hold_q  <= '0;
            end else begin
                state_q <= state_d;
                deb_q   <= deb_d;
                hold_q  <= hold_d;
            end
        end

        always_comb begin
            state_d = state_q;
            deb_d   = deb_q;
            hold_d  = hold_q;
            accept  = 1'b0;
            stk_set = 1'b0;
            case (state_q)
                S_REL: begin
                    if (sync_q[gi]) begin
                        state_d = S_DBP;
                        deb_d   = '0;
                    end
                end
                S_DBP: begin
                    if (!sync_q[gi]) begin
                        state_d = S_REL;
                    end else if (deb_q >= c_DEB_LAST) begin
                        state_d = S_PRS;
                        hold_d  = '0;
                        accept  = 1'b1;
                    end else begin
                        deb_d = deb_q + c_DEB_ONE;
                    end
                end
                S_PRS: begin
                    if (!sync_q[gi]) begin
                        state_d = S_DBR;
                        deb_d   = '0;
                    end else if (hold_q >= c_HOLD_LAST) begin
                        state_d = S_STK;
                        deb_d   = '0;
                        stk_set = 1'b1;
                    end else begin
                        hold_d = hold_q + c_HOLD_ONE;
                    end
                end
                S_DBR: begin
                    // Hold time survives a release bounce so a chattering stuck button is still caught.
                    if (sync_q[gi]) begin
                        state_d = S_PRS;
                    end else if (deb_q >= c_DEB_LAST) begin
                        state_d = S_REL;
                    end else begin
                        deb_d = deb_q + c_DEB_ONE;
                    end
                end
                S_STK: begin
                    if (sync_q[gi]) begin
                        deb_d = '0;
                    end else if (deb_q >= c_DEB_LAST) begin
                        state_d = S_REL;
                    end else begin
                        deb_d = deb_q + c_DEB_ONE;
                    end
                end
                default: state_d = S_REL;
            endcase
        end

        assign w_accept[gi]  = accept;
        assign w_stk_set[gi] = stk_set;
    end

    // Lamps of faulted floors are dropped so a cleared fault does not leave a stale lamp blocking the next press.
    always_comb begin
        req_d   = w_accept & ~lamp_q & ~w_serve;
        fault_d = (fault_q & ~{8{fault_clr_i}}) | w_stk_set;
        lamp_d  = (lamp_q | req_q) & ~w_serve & ~fault_d;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            req_q       <= '0;
            lamp_q      <= '0;
            fault_q     <= '0;
            any_fault_q <= 1'b0;
        end else begin
            req_q       <= req_d;
            lamp_q      <= lamp_d;
            fault_q     <= fault_d;
            any_fault_q <= |fault_d;
        end
    end

`ifdef LAMP_BLINK_EN
    localparam int c_BLINK_W = $clog2(BLINK_HALF_PERIOD + 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_HALF_PERIOD - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_ONE  = c_BLINK_W'(1);

    logic [c_BLINK_W-1:0] blink_cnt_q;
    logic                 blink_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q >= c_BLINK_LAST) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + c_BLINK_ONE;
        end
    end

    assign lamp_o = (lamp_q & ~fault_q) | (fault_q & {8{blink_q}});
`else
    assign lamp_o = lamp_q & ~fault_q;
`endif

    assign req_o       = req_q;
    assign fault_o     = fault_q;
    assign any_fault_o = any_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_call_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_call_button_conditioner
// Purpose  : Self-checking bench: directed vector table, latency/reset
//            sequences and random stimulus against a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_call_button_conditioner;
    localparam int c_DEB   = 4;
    localparam int c_STUCK = 20;
    localparam int c_BLINK = 3;
    localparam int M_REL   = 0;
    localparam int M_PRS   = 1;
    localparam int M_STK   = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] btn = '0;
    logic [2:0] cur_floor = '0;
    logic       door = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] req, lamp, fault;
    logic       any_fault;

    always #5 clk = ~clk;

    call_button_conditioner #(
        .DEBOUNCE_CYCLES  (c_DEB),
        .STUCK_CYCLES     (c_STUCK),
        .BLINK_HALF_PERIOD(c_BLINK)
    ) dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .btn_raw_i      (btn),
        .current_floor_i(cur_floor),
        .door_open_i    (door),
        .fault_clr_i    (clr),
        .req_o          (req),
        .lamp_o         (lamp),
        .fault_o        (fault),
        .any_fault_o    (any_fault)
    );

    int errors = 0;
    int checks = 0;

    // Reference: each floor is released, pressed or stuck; transitions are
    // decided by the length of the current run of equal synchronized levels.
    int         m_mode [8];
    int         m_run  [8];
    int         m_hold [8];
    logic [7:0] m_prev, m_s1, m_s, m_req, m_lamp, m_fault;
    logic       m_any;
    int         m_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_mode[i] = M_REL;
            m_run[i]  = 0;
            m_hold[i] = 0;
        end
        m_prev = '0; m_s1 = '0; m_s = '0;
        m_req = '0; m_lamp = '0; m_fault = '0; m_any = 1'b0; m_cyc = 0;
    endtask

    task automatic model_step();
        logic [7:0] serve, acc, stk, nf, nreq, nlamp;
        serve = '0;
        if (door) serve[cur_floor] = 1'b1;
        acc = '0;
        stk = '0;
        for (int i = 0; i < 8; i++) begin
            logic s;
            int   run;
            s   = m_s[i];
            run = (s == m_prev[i]) ? m_run[i] + 1 : 1;
            case (m_mode[i])
                M_REL: if (s && run == c_DEB + 1) begin
                    acc[i]    = 1'b1;
                    m_mode[i] = M_PRS;
                    m_hold[i] = 0;
                end
                M_PRS: begin
                    if (!s && run == c_DEB + 1) m_mode[i] = M_REL;
                    else if (s && m_prev[i]) begin
                        if (m_hold[i] == c_STUCK - 1) begin
                            stk[i]    = 1'b1;
                            m_mode[i] = M_STK;
                        end else m_hold[i]++;
                    end
                end
                default: if (!s && run == c_DEB) m_mode[i] = M_REL;
            endcase
            m_run[i]  = run;
            m_prev[i] = s;
        end
        nf    = (m_fault & ~{8{clr}}) | stk;
        nreq  = acc & ~m_lamp & ~serve;
        nlamp = (m_lamp | m_req) & ~serve & ~nf;
        m_req = nreq; m_lamp = nlamp; m_fault = nf; m_any = |nf;
        m_s = m_s1; m_s1 = btn;
        m_cyc++;
    endtask

    function automatic logic [7:0] exp_lamp();
`ifdef LAMP_BLINK_EN
        logic ph;
        ph = ((m_cyc / c_BLINK) % 2) == 1;
        return (m_lamp & ~m_fault) | (m_fault & {8{ph}});
`else
        return m_lamp;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
        check("req", req, m_req);
        check("lamp", lamp, exp_lamp());
        check("fault", fault, m_fault);
        check("any_fault", any_fault, m_any);
    endtask

    task automatic measure(input string name, input logic [7:0] exp_req, input int exp_ticks);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (req != 8'h00) got = 1'b1;
        end
        check({name, "_latency"}, n, exp_ticks);
        check({name, "_req"}, req, exp_req);
        tick();
        check({name, "_width"}, req, 8'h00);
    endtask

    typedef struct {
        logic [7:0] btn;
        logic [2:0] flr;
        logic       door;
        logic       clr;
        int         n;
        logic [7:0] e_req;
        logic [7:0] e_lamp;
        logic [7:0] e_fault;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] seen;
        //                btn    flr   door  clr   n   req    lamp   fault
        tbl.push_back('{8'h08, 3'd0, 1'b0, 1'b0, 10, 8'h08, 8'h08, 8'h00}); // clean press
        tbl.push_back('{8'h00, 3'd0, 1'b0, 1'b0,  8, 8'h00, 8'h08, 8'h00});
        tbl.push_back('{8'h20, 3'd0, 1'b0, 1'b0,  1, 8'h00, 8'h08, 8'h00}); // bounce 1,1,0,1,1,1,0
        tbl.push_back('{8'h20, 3'd0, 1'b0, 1'b0,  1, 8'h00, 8'h08, 8'h00});
        tbl.push_back('{8'h00, 3'd0, 1'b0, 1'b0,  1, 8'h00, 8'h08, 8'h00});
        tbl.push_back('{8'h20, 3'd0, 1'b0, 1'b0,  1, 8'h00, 8'h08, 8'h00});
        tbl.push_back('{8'h20, 3'd0, 1'b0, 1'b0,  1, 8'h00, 8'h08, 8'h00});
        tbl.push_back('{8'h20, 3'd0, 1'b0, 1'b0,  1, 8'h00, 8'h08, 8'h00});
        tbl.push_back('{8'h00, 3'd0, 1'b0, 1'b0,  1, 8'h00, 8'h08, 8'h00});
        tbl.push_back('{8'h20, 3'd0, 1'b0, 1'b0, 10, 8'h20, 8'h28, 8'h00});
        tbl.push_back('{8'h00, 3'd0, 1'b0, 1'b0,  8, 8'h00, 8'h28, 8'h00});
        tbl.push_back('{8'h04, 3'd0, 1'b0, 1'b0, 10, 8'h04, 8'h2C, 8'h00}); // service clear
        tbl.push_back('{8'h04, 3'd2, 1'b1, 1'b0,  1, 8'h00, 8'h28, 8'h00});
        tbl.push_back('{8'h00, 3'd2, 1'b1, 1'b0,  8, 8'h00, 8'h28, 8'h00});
        tbl.push_back('{8'h04, 3'd2, 1'b1, 1'b0, 10, 8'h00, 8'h28, 8'h00}); // press while served
        tbl.push_back('{8'h00, 3'd2, 1'b0, 1'b0,  8, 8'h00, 8'h28, 8'h00});
        tbl.push_back('{8'h81, 3'd0, 1'b0, 1'b0, 10, 8'h81, 8'hA9, 8'h00}); // multi-floor
        tbl.push_back('{8'h81, 3'd0, 1'b0, 1'b0, 20, 8'h00, 8'h28, 8'h81}); // stuck
        tbl.push_back('{8'h00, 3'd0, 1'b0, 1'b0,  6, 8'h00, 8'h28, 8'h81});
        tbl.push_back('{8'h00, 3'd0, 1'b0, 1'b1,  1, 8'h00, 8'h28, 8'h00}); // fault clear
        tbl.push_back('{8'h80, 3'd0, 1'b0, 1'b0, 10, 8'h80, 8'hA8, 8'h00});
        tbl.push_back('{8'h00, 3'd0, 1'b0, 1'b0,  8, 8'h00, 8'hA8, 8'h00});

        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;

        foreach (tbl[k]) begin
            btn = tbl[k].btn; cur_floor = tbl[k].flr; door = tbl[k].door; clr = tbl[k].clr;
            seen = '0;
            repeat (tbl[k].n) begin
                tick();
                seen |= req;
            end
            check($sformatf("tbl%0d_req", k), seen, tbl[k].e_req);
            check($sformatf("tbl%0d_lamp", k), lamp & ~fault, tbl[k].e_lamp);
            check($sformatf("tbl%0d_fault", k), fault, tbl[k].e_fault);
        end
        clr = 1'b0; door = 1'b0;

        // First sampling edge is tick 1; req follows 2+DEBOUNCE edges later.
        btn = 8'h02;
        measure("press_latency", 8'h02, 7);
        repeat (3) tick();
        btn = 8'h00;
        repeat (8) tick();

        btn = 8'h02;
        repeat (3) tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("reset_async_req", req, 8'h00);
        check("reset_async_lamp", lamp, 8'h00);
        repeat (2) tick();
        check("reset_hold_fault", fault, 8'h00);
        check("reset_hold_any", any_fault, 1'b0);
        reset_n = 1'b1;
        measure("post_reset", 8'h02, 7);
        btn = 8'h00;
        repeat (8) tick();

        for (int t = 0; t < 600; t++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
            if ($urandom_range(0, 7) == 0) door = ~door;
            if ($urandom_range(0, 9) == 0) cur_floor = 3'($urandom_range(0, 7));
            clr = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
